// File: rtl/rpn_stack.sv
// Operand stack for the RPN calculator: top entry in a register, deeper entries in a
// block RAM with a registered read port. Optional high-water mark: RPN_STACK_PEAK_EN.
module rpn_stack #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 9,
  parameter int SIZE_BITS = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 replace,
  input  logic                 clr,
  input  logic [WIDTH-1:0]     in_num,
  output logic [WIDTH-1:0]     top,
  output logic [SIZE_BITS-1:0] size,
  output logic                 error,
  output logic                 out_vld
`ifdef RPN_STACK_PEAK_EN
  ,
  output logic [SIZE_BITS-1:0] peak
`endif
);

  localparam int                   DEPTH   = 2 ** ADDR_BITS;
  localparam logic [SIZE_BITS-1:0] DEPTH_S = SIZE_BITS'(DEPTH);
  localparam logic [SIZE_BITS-1:0] ZERO_S  = {SIZE_BITS{1'b0}};
  localparam logic [SIZE_BITS-1:0] ONE_S   = SIZE_BITS'(1);
  localparam logic [SIZE_BITS-1:0] TWO_S   = SIZE_BITS'(2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    LD   = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_s;
  logic [WIDTH-1:0]       top_r;
  logic [WIDTH-1:0]       top_s;
  logic [SIZE_BITS-1:0]   size_r;
  logic [SIZE_BITS-1:0]   size_s;
  logic                   error_r;
  logic                   error_s;
  logic                   out_vld_r;
  logic                   out_vld_s;
  logic [ADDR_BITS-1:0]   rd_addr_r;
  logic [ADDR_BITS-1:0]   rd_addr_s;
  logic [ADDR_BITS-1:0]   wr_addr_s;
  logic                   wr_en_s;
  logic                   any_cmd_s;
  logic [WIDTH-1:0]       ram_q_r;
  logic [WIDTH-1:0]       ram_r [0:DEPTH-1];

  assign any_cmd_s = push | pop | replace | clr;

  // Next-state and datapath decode; commands only act in IDLE, otherwise they flag an error.
  always_comb begin
    state_s   = state_r;
    top_s     = top_r;
    size_s    = size_r;
    error_s   = error_r;
    out_vld_s = out_vld_r;
    rd_addr_s = rd_addr_r;
    wr_en_s   = 1'b0;
    wr_addr_s = ADDR_BITS'(size_r - ONE_S);
    case (state_r)
      IDLE: begin
        if (clr) begin
          top_s   = {WIDTH{1'b0}};
          size_s  = ZERO_S;
          error_s = 1'b0;
        end else if (push) begin
          if (size_r == DEPTH_S) begin
            error_s = 1'b1;
          end else if (size_r == ZERO_S) begin
            top_s  = in_num;
            size_s = ONE_S;
          end else begin
            // Old top spills into RAM at index size-1 on this same edge.
            wr_en_s = 1'b1;
            top_s   = in_num;
            size_s  = size_r + ONE_S;
          end
        end else if (pop) begin
          if (size_r == ZERO_S) begin
            error_s = 1'b1;
          end else if (size_r == ONE_S) begin
            top_s  = {WIDTH{1'b0}};
            size_s = ZERO_S;
          end else begin
            size_s    = size_r - ONE_S;
            rd_addr_s = ADDR_BITS'(size_r - TWO_S);
            out_vld_s = 1'b0;
            state_s   = RD;
          end
        end else if (replace) begin
          if (size_r == ZERO_S) begin
            error_s = 1'b1;
          end else begin
            top_s = in_num;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RD: begin
        state_s = LD;
        if (any_cmd_s) begin
          error_s = 1'b1;
        end else begin
          error_s = error_r;
        end
      end
      LD: begin
        top_s     = ram_q_r;
        out_vld_s = 1'b1;
        state_s   = IDLE;
        if (any_cmd_s) begin
          error_s = 1'b1;
        end else begin
          error_s = error_r;
        end
      end
      default: begin
        state_s   = IDLE;
        out_vld_s = 1'b1;
      end
    endcase
  end

  // Control and top-of-stack registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      top_r     <= {WIDTH{1'b0}};
      size_r    <= ZERO_S;
      error_r   <= 1'b0;
      out_vld_r <= 1'b1;
      rd_addr_r <= {ADDR_BITS{1'b0}};
    end else begin
      state_r   <= state_s;
      top_r     <= top_s;
      size_r    <= size_s;
      error_r   <= error_s;
      out_vld_r <= out_vld_s;
      rd_addr_r <= rd_addr_s;
    end
  end

  // Block RAM: synchronous write, registered read loaded during RD.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      ram_r[wr_addr_s] <= top_r;
    end
    if (state_r == RD) begin
      ram_q_r <= ram_r[rd_addr_r];
    end
  end

`ifdef RPN_STACK_PEAK_EN
  logic [SIZE_BITS-1:0] peak_r;
  logic [SIZE_BITS-1:0] peak_s;

  // High-water mark follows size on the same edge; an accepted clr empties it.
  always_comb begin
    peak_s = peak_r;
    if ((state_r == IDLE) && clr) begin
      peak_s = ZERO_S;
    end else if (size_s > peak_r) begin
      peak_s = size_s;
    end else begin
      peak_s = peak_r;
    end
  end

  // High-water mark register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak_r <= ZERO_S;
    end else begin
      peak_r <= peak_s;
    end
  end

  assign peak = peak_r;
`endif

  assign top     = top_r;
  assign size    = size_r;
  assign error   = error_r;
  assign out_vld = out_vld_r;

endmodule

// File: tb/tb_rpn_stack.sv
// Directed bench for rpn_stack: a vector table for single commands and pop sequencing,
// plus hand-written fill/overflow, reset-during-read and (optional) peak sequences.
module tb_rpn_stack;

  localparam int WIDTH     = 32;
  localparam int ADDR_BITS = 9;
  localparam int SIZE_BITS = 10;
  localparam int DEPTH     = 2 ** ADDR_BITS;

  logic                 clk;
  logic                 reset;
  logic                 push;
  logic                 pop;
  logic                 replace;
  logic                 clr;
  logic [WIDTH-1:0]     in_num;
  logic [WIDTH-1:0]     top;
  logic [SIZE_BITS-1:0] size;
  logic                 error;
  logic                 out_vld;
`ifdef RPN_STACK_PEAK_EN
  logic [SIZE_BITS-1:0] peak;
`endif

  rpn_stack #(
    .WIDTH    (WIDTH),
    .ADDR_BITS(ADDR_BITS),
    .SIZE_BITS(SIZE_BITS)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .replace(replace),
    .clr    (clr),
    .in_num (in_num),
    .top    (top),
    .size   (size),
    .error  (error),
    .out_vld(out_vld)
`ifdef RPN_STACK_PEAK_EN
    ,
    .peak   (peak)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        c_push;
    logic        c_pop;
    logic        c_rep;
    logic        c_clr;
    logic [31:0] num;
    logic [31:0] e_top;
    logic [31:0] e_size;
    logic        e_err;
    logic        e_vld;
  } vec_t;

  vec_t vq[$];
  int   n_vec;
  int   n_bad;

  task automatic add(input logic p, input logic po, input logic r, input logic c,
                     input logic [31:0] num, input logic [31:0] t, input logic [31:0] s,
                     input logic e, input logic v);
    vec_t x;
    x.c_push = p; x.c_pop = po; x.c_rep = r; x.c_clr = c; x.num = num;
    x.e_top = t; x.e_size = s; x.e_err = e; x.e_vld = v;
    vq.push_back(x);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; drives one command for one rising edge, returns at the next negedge.
  task automatic step(input logic p, input logic po, input logic r, input logic c,
                      input logic [31:0] num);
    push = p; pop = po; replace = r; clr = c; in_num = num;
    @(negedge clk);
    push = 1'b0; pop = 1'b0; replace = 1'b0; clr = 1'b0; in_num = 32'h0;
  endtask

  task automatic check_state(input string tag, input logic [31:0] t, input logic [31:0] s,
                             input logic e, input logic v);
    check({tag, ".top"}, top, t);
    check({tag, ".size"}, 32'(size), s);
    check({tag, ".error"}, 32'(error), 32'(e));
    check({tag, ".out_vld"}, 32'(out_vld), 32'(v));
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    reset = 1'b1; push = 1'b0; pop = 1'b0; replace = 1'b0; clr = 1'b0; in_num = 32'h0;

    //      push  pop   rep   clr   num        top        size   err   vld
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'h5,     32'h5,     32'd1, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'h7,     32'h7,     32'd2, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,     32'h7,     32'd1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,     32'h7,     32'd1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,     32'h5,     32'd1, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,     32'h0,     32'd0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,     32'h0,     32'd0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 32'h12,    32'h0,     32'd0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,     32'h0,     32'd0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'hA,     32'hA,     32'd1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 32'hB,     32'hB,     32'd1, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'hC,     32'hC,     32'd2, 1'b0, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'hD,     32'hD,     32'd3, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,     32'hD,     32'd2, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'hE,     32'hD,     32'd2, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,     32'hC,     32'd2, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,     32'hC,     32'd1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,     32'hC,     32'd1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,     32'hB,     32'd1, 1'b1, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b1, 32'h9,     32'h0,     32'd0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'h3,     32'h3,     32'd1, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 32'h55,    32'h0,     32'd0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'h1,     32'h1,     32'd1, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'h2,     32'h2,     32'd2, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b1, 1'b0, 32'h3,     32'h3,     32'd3, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,     32'h0,     32'd0, 1'b0, 1'b1);

    repeat (2) @(negedge clk);
    check_state("reset", 32'h0, 32'd0, 1'b0, 1'b1);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].c_push, vq[i].c_pop, vq[i].c_rep, vq[i].c_clr, vq[i].num);
      check_state($sformatf("vec%0d", i), vq[i].e_top, vq[i].e_size, vq[i].e_err, vq[i].e_vld);
    end

    // Fill to capacity, overflow, then drain to one entry checking order and pop latency.
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'(i));
    end
    check_state("full", 32'(DEPTH), 32'(DEPTH), 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF);
    check_state("overflow", 32'(DEPTH), 32'(DEPTH), 1'b1, 1'b1);
    for (int j = 1; j < DEPTH; j++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      check("drain.vld_low1", 32'(out_vld), 32'd0);
      @(negedge clk);
      check("drain.vld_low2", 32'(out_vld), 32'd0);
      @(negedge clk);
      check($sformatf("drain%0d.vld", j), 32'(out_vld), 32'd1);
      check($sformatf("drain%0d.top", j), top, 32'(DEPTH - j));
      check($sformatf("drain%0d.size", j), 32'(size), 32'(DEPTH - j));
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    check_state("clr_after_drain", 32'h0, 32'd0, 1'b0, 1'b1);

    // Asynchronous reset while the pop read is in flight.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h2);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("rd.vld", 32'(out_vld), 32'd0);
    #2 reset = 1'b1;
    #1 check_state("async_reset", 32'h0, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h9);
    check_state("post_reset_push", 32'h9, 32'd1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_state("post_reset_idle", 32'h9, 32'd1, 1'b0, 1'b1);

`ifdef RPN_STACK_PEAK_EN
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    check("peak.clr", 32'(peak), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h3);
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      repeat (2) @(negedge clk);
    end
    check("peak.size", 32'(size), 32'd1);
    check("peak.hwm", 32'(peak), 32'd3);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    check("peak.cleared", 32'(peak), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
